// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter/timer family.
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_t;

  localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with a registered terminal-count pulse
// and optional periodic auto-reload.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  cnt_state_t       state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode;
  logic             at_one;
  logic             load_zero;

  // Single terminal compare serves both the one-shot and the reload exits.
  assign at_one    = (count == WIDTH'(1));
  assign load_zero = (load_val == '0);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode       <= 1'b0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        count      <= load_val;
        reload_reg <= load_val;
        // A zero load finishes immediately and is never periodic.
        if (load_zero) begin
          tc    <= 1'b1;
          mode  <= 1'b0;
          state <= IDLE;
        end else begin
          mode  <= auto_reload;
          state <= RUN;
        end
      end else if (state == RUN && tick) begin
        if (at_one) begin
          tc <= 1'b1;
          if (mode) begin
            count <= reload_reg;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, tick, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, tc;

  int checks   = 0;
  int failures = 0;
  int pulses;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .count       (count),
    .busy        (busy),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] c, input logic b, input logic t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    auto_reload = 1'b0; load_val = '0;
    #1;
    chk_out("reset", 4'd0, 1'b0, 1'b0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk_out("idle_after_reset", 4'd0, 1'b0, 1'b0);

    // One-shot of 3
    load_val = 4'd3; auto_reload = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("os_start", 4'd3, 1'b1, 1'b0);
    tick = 1'b1;
    cyc(); chk_out("os_t1", 4'd2, 1'b1, 1'b0);
    cyc(); chk_out("os_t2", 4'd1, 1'b1, 1'b0);
    cyc(); chk_out("os_t3", 4'd0, 1'b0, 1'b1);
    cyc(); chk_out("os_after", 4'd0, 1'b0, 1'b0);

    // Periodic with reload 2; coincident tick on start is discarded
    load_val = 4'd2; auto_reload = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("per_start", 4'd2, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_out("per_tick", (i % 2 == 0) ? 4'd1 : 4'd2, 1'b1, (i % 2 == 1));
      if (tc) pulses++;
    end
    chk("per_pulses", 32'(pulses), 32'd3);

    // stop + start together: stop wins, count holds, no tc
    stop = 1'b1; start = 1'b1; load_val = 4'd9;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk_out("stop_start", 4'd2, 1'b0, 1'b0);
    cyc();
    chk_out("stop_idle_tick", 4'd2, 1'b0, 1'b0);

    // Restart in RUN discards coincident tick
    tick = 1'b0; load_val = 4'd5; auto_reload = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("rs_load5", 4'd5, 1'b1, 1'b0);
    tick = 1'b1;
    cyc();
    chk_out("rs_tick", 4'd4, 1'b1, 1'b0);
    start = 1'b1; load_val = 4'd9;
    cyc();
    start = 1'b0; tick = 1'b0;
    chk_out("rs_restart9", 4'd9, 1'b1, 1'b0);
    cyc();
    chk_out("rs_hold", 4'd9, 1'b1, 1'b0);

    // Asynchronous reset mid-count at 5
    load_val = 4'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("ar_pre", 4'd5, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_out("ar_async", 4'd0, 1'b0, 1'b0);
    cyc();
    reset = 1'b1; tick = 1'b1;
    cyc(); cyc();
    chk_out("ar_post_ticks", 4'd0, 1'b0, 1'b0);
    tick = 1'b0;

    // Gated ticks: one tick every third cycle, load 4
    load_val = 4'd4; auto_reload = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("gt_start", 4'd4, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk_out("gt_tick", 4'(4 - k), (k != 4), (k == 4));
      cyc();
      chk_out("gt_hold1", 4'(4 - k), (k != 4), 1'b0);
      cyc();
      chk_out("gt_hold2", 4'(4 - k), (k != 4), 1'b0);
    end

    // Zero load with auto_reload: single tc, stays idle
    load_val = 4'd0; auto_reload = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b1;
    chk_out("zero_load", 4'd0, 1'b0, 1'b1);
    cyc();
    chk_out("zero_after", 4'd0, 1'b0, 1'b0);

    // Periodic reload of 1 with tick held: tc every cycle
    load_val = 4'd1; auto_reload = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("p1_start", 4'd1, 1'b1, 1'b0);
    cyc(); chk_out("p1_a", 4'd1, 1'b1, 1'b1);
    cyc(); chk_out("p1_b", 4'd1, 1'b1, 1'b1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_out("p1_stop", 4'd1, 1'b0, 1'b0);

    // Full-scale one-shot: 15 ticks to tc
    load_val = 4'd15; auto_reload = 1'b0; start = 1'b1; tick = 1'b0;
    cyc();
    start = 1'b0; tick = 1'b1;
    chk_out("fs_start", 4'd15, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk_out("fs_tick", 4'(15 - i), (i != 15), (i == 15));
    end
    tick = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
